// File: rtl/issue_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// issue_scheduler_pkg
// Shared constants and types for the warp issue scheduler.
//   - default field widths (the top-level parameters default to these)
//   - WID_BITS : warp-id width
//   - SB_REGS  : number of scoreboard busy bits per warp
//   - issue_bundle_t : the packed instruction bundle held in the issue register
//   - next_warp() : round-robin pointer advance with wrap-around
// ---------------------------------------------------------------------------
package issue_scheduler_pkg;

    localparam int NUM_WARPS_D = 8;
    localparam int ARCH_LEN_D  = 32;
    localparam int OP_BITS_D   = 9;
    localparam int REG_BITS_D  = 8;
    localparam int NUM_LANES_D = 16;
    localparam int IMM_BITS_D  = 32;

    localparam int WID_BITS = (NUM_WARPS_D > 1) ? $clog2(NUM_WARPS_D) : 1;
    localparam int SB_REGS  = 1 << REG_BITS_D;

    // Bundle sized from the package defaults; the top-level parameters
    // must be left at (or kept consistent with) these values.
    typedef struct packed {
        logic [WID_BITS-1:0]    wid;
        logic [ARCH_LEN_D-1:0]  pc;
        logic [OP_BITS_D-1:0]   op;
        logic [REG_BITS_D-1:0]  rd;
        logic [REG_BITS_D-1:0]  rs1;
        logic [REG_BITS_D-1:0]  rs2;
        logic [REG_BITS_D-1:0]  rs3;
        logic [IMM_BITS_D-1:0]  imm;
        logic [NUM_LANES_D-1:0] tmask;
    } issue_bundle_t;

    // Pointer to the warp after w, wrapping from n-1 back to 0.
    function automatic logic [WID_BITS-1:0] next_warp(input logic [WID_BITS-1:0] w,
                                                      input int n);
        if (int'(w) >= n - 1) begin
            return '0;
        end
        return w + WID_BITS'(1);
    endfunction

endpackage

// File: rtl/issue_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. Searches upward from i_ptr,
// wrapping from N-1 to 0, and grants the first requester found.
//   i_req   : request vector, one bit per warp
//   i_ptr   : index with highest priority this cycle
//   o_grant : one-hot grant (all zero when nothing requests)
//   o_valid : at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N  = 8,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic          o_valid
);

    logic [2*N-1:0] w_req_dbl;
    logic [N-1:0]   w_req_rot;
    logic [N-1:0]   w_gnt_rot;
    logic [2*N-1:0] w_gnt_dbl;

    // Rotate requests right by i_ptr so the highest-priority warp sits at
    // bit 0; a fixed lowest-bit-first search then implements round-robin.
    assign w_req_dbl = {i_req, i_req} >> i_ptr;
    assign w_req_rot = w_req_dbl[N-1:0];

    always_comb begin
        w_gnt_rot = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_gnt_rot    = '0;
                w_gnt_rot[k] = 1'b1;
            end
        end
    end

    // Rotate the one-hot grant back into warp numbering.
    assign w_gnt_dbl = {{N{1'b0}}, w_gnt_rot} << i_ptr;
    assign o_grant   = w_gnt_dbl[2*N-1:N] | w_gnt_dbl[N-1:0];
    assign o_valid   = |i_req;

endmodule

// File: rtl/issue_scheduler.sv
// ---------------------------------------------------------------------------
// issue_scheduler
// Picks one ready warp per cycle from the per-warp instruction-buffer heads
// and hands it to the execute stage through a single output register.
// A per-warp register scoreboard blocks RAW and WAW hazards; writeback
// clears busy bits.
//
// Ports
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_ibuf_*                : per-warp ibuf head (slot g at [W*g +: W])
//   o_ibuf_ready            : one-hot pop of the selected warp's head
//   o_iss_valid/i_iss_ready : issue handshake, o_iss_* bundle fields
//   i_wb_valid/wid/rd       : scoreboard clear from writeback
//   o_perf_issued           : instructions issued (wraps at 2^32)
//   o_perf_hazard_stalls    : cycles with a valid warp but none eligible
//
// Handshake semantics (both the ibuf side and the issue side): a transfer
// happens on a rising edge where valid and ready are both 1. The producer
// holds valid and payload stable until the transfer; ready may depend
// combinationally on valid. o_ibuf_ready is driven within the same cycle
// from i_ibuf_valid and registered state; the popped instruction appears
// on o_iss_valid one cycle later.
// ---------------------------------------------------------------------------
module issue_scheduler import issue_scheduler_pkg::*; #(
    parameter int NUM_WARPS = NUM_WARPS_D,
    parameter int ARCH_LEN  = ARCH_LEN_D,
    parameter int OP_BITS   = OP_BITS_D,
    parameter int REG_BITS  = REG_BITS_D,
    parameter int NUM_LANES = NUM_LANES_D,
    parameter int IMM_BITS  = IMM_BITS_D,
    parameter int WID_W     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    // instruction buffer heads
    input  logic [NUM_WARPS-1:0]           i_ibuf_valid,
    output logic [NUM_WARPS-1:0]           o_ibuf_ready,
    input  logic [NUM_WARPS*ARCH_LEN-1:0]  i_ibuf_pc,
    input  logic [NUM_WARPS*OP_BITS-1:0]   i_ibuf_op,
    input  logic [NUM_WARPS*REG_BITS-1:0]  i_ibuf_rd,
    input  logic [NUM_WARPS*REG_BITS-1:0]  i_ibuf_rs1,
    input  logic [NUM_WARPS*REG_BITS-1:0]  i_ibuf_rs2,
    input  logic [NUM_WARPS*REG_BITS-1:0]  i_ibuf_rs3,
    input  logic [NUM_WARPS*IMM_BITS-1:0]  i_ibuf_imm32,
    input  logic [NUM_WARPS*NUM_LANES-1:0] i_ibuf_tmask,
    // issue port
    output logic                           o_iss_valid,
    input  logic                           i_iss_ready,
    output logic [WID_W-1:0]               o_iss_wid,
    output logic [ARCH_LEN-1:0]            o_iss_pc,
    output logic [OP_BITS-1:0]             o_iss_op,
    output logic [REG_BITS-1:0]            o_iss_rd,
    output logic [REG_BITS-1:0]            o_iss_rs1,
    output logic [REG_BITS-1:0]            o_iss_rs2,
    output logic [REG_BITS-1:0]            o_iss_rs3,
    output logic [IMM_BITS-1:0]            o_iss_imm32,
    output logic [NUM_LANES-1:0]           o_iss_tmask,
    // writeback
    input  logic                           i_wb_valid,
    input  logic [WID_W-1:0]               i_wb_wid,
    input  logic [REG_BITS-1:0]            i_wb_rd,
    // performance counters
    output logic [31:0]                    o_perf_issued,
    output logic [31:0]                    o_perf_hazard_stalls
);

    // ---------------- state ----------------
    logic [SB_REGS-1:0] r_busy [NUM_WARPS];
    logic [WID_W-1:0]   r_rr_ptr;
    issue_bundle_t      r_iss;
    logic               r_iss_valid;
    logic [31:0]        r_perf_issued;
    logic [31:0]        r_perf_hazard_stalls;

    // ---------------- combinational ----------------
    logic [NUM_WARPS-1:0] w_elig;
    logic [NUM_WARPS-1:0] w_grant;
    logic                 w_sel_valid;
    issue_bundle_t        w_sel;
    logic                 w_fire;
    logic                 w_issue;
    logic                 w_stall;

    // Hazard check reads only the registered scoreboard, so a writeback in
    // this cycle unblocks a warp no earlier than the next cycle.
    always_comb begin
        w_elig = '0;
        for (int g = 0; g < NUM_WARPS; g++) begin
            w_elig[g] = i_ibuf_valid[g]
                & ~r_busy[g][i_ibuf_rs1[g*REG_BITS +: REG_BITS]]
                & ~r_busy[g][i_ibuf_rs2[g*REG_BITS +: REG_BITS]]
                & ~r_busy[g][i_ibuf_rs3[g*REG_BITS +: REG_BITS]]
                & ~r_busy[g][i_ibuf_rd [g*REG_BITS +: REG_BITS]];
        end
    end

    rr_arbiter #(
        .N  (NUM_WARPS),
        .PW (WID_W)
    ) u_rr_arbiter (
        .i_req   (w_elig),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_valid (w_sel_valid)
    );

    // One-hot mux of the granted warp's head fields.
    always_comb begin
        w_sel = '0;
        for (int g = 0; g < NUM_WARPS; g++) begin
            if (w_grant[g]) begin
                w_sel.wid   = WID_BITS'(g);
                w_sel.pc    = i_ibuf_pc   [g*ARCH_LEN  +: ARCH_LEN];
                w_sel.op    = i_ibuf_op   [g*OP_BITS   +: OP_BITS];
                w_sel.rd    = i_ibuf_rd   [g*REG_BITS  +: REG_BITS];
                w_sel.rs1   = i_ibuf_rs1  [g*REG_BITS  +: REG_BITS];
                w_sel.rs2   = i_ibuf_rs2  [g*REG_BITS  +: REG_BITS];
                w_sel.rs3   = i_ibuf_rs3  [g*REG_BITS  +: REG_BITS];
                w_sel.imm   = i_ibuf_imm32[g*IMM_BITS  +: IMM_BITS];
                w_sel.tmask = i_ibuf_tmask[g*NUM_LANES +: NUM_LANES];
            end
        end
    end

    // The output register can take a new bundle when empty or draining.
    assign w_fire  = ~r_iss_valid | i_iss_ready;
    assign w_issue = w_fire & w_sel_valid & ~i_rst;
    assign w_stall = (|i_ibuf_valid) & ~w_sel_valid;

    assign o_ibuf_ready = w_issue ? w_grant : '0;

    // ---------------- sequential ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_iss                <= '0;
            r_iss_valid          <= 1'b0;
            r_rr_ptr             <= '0;
            r_perf_issued        <= '0;
            r_perf_hazard_stalls <= '0;
            for (int g = 0; g < NUM_WARPS; g++) begin
                r_busy[g] <= '0;
            end
        end else begin
            // Clear first; a same-bit issue set below is the later
            // non-blocking assignment and therefore wins.
            if (i_wb_valid && (i_wb_rd != '0) && (int'(i_wb_wid) < NUM_WARPS)) begin
                r_busy[i_wb_wid][i_wb_rd] <= 1'b0;
            end
            if (w_issue && (w_sel.rd != '0)) begin
                r_busy[w_sel.wid][w_sel.rd] <= 1'b1;
            end

            if (w_fire) begin
                r_iss_valid <= w_sel_valid;
                if (w_sel_valid) begin
                    r_iss <= w_sel;
                end
            end

            if (w_issue) begin
                r_rr_ptr      <= next_warp(w_sel.wid, NUM_WARPS);
                r_perf_issued <= r_perf_issued + 32'd1;
            end

            if (w_stall) begin
                r_perf_hazard_stalls <= r_perf_hazard_stalls + 32'd1;
            end
        end
    end

    // ---------------- outputs ----------------
    assign o_iss_valid          = r_iss_valid;
    assign o_iss_wid            = r_iss.wid;
    assign o_iss_pc             = r_iss.pc;
    assign o_iss_op             = r_iss.op;
    assign o_iss_rd             = r_iss.rd;
    assign o_iss_rs1            = r_iss.rs1;
    assign o_iss_rs2            = r_iss.rs2;
    assign o_iss_rs3            = r_iss.rs3;
    assign o_iss_imm32          = r_iss.imm;
    assign o_iss_tmask          = r_iss.tmask;
    assign o_perf_issued        = r_perf_issued;
    assign o_perf_hazard_stalls = r_perf_hazard_stalls;

endmodule

// File: tb/tb_issue_scheduler.sv
// ---------------------------------------------------------------------------
// tb_issue_scheduler
// Bench for issue_scheduler (default 8 warps). A reference model running on
// the falling edge predicts ibuf_ready, iss_valid and the perf counters each
// cycle and queues the expected issue bundles for comparison when they
// transfer. A vector table covers round-robin order and reset; short
// hand-written sequences cover the multi-cycle hazard and stall cases.
// ---------------------------------------------------------------------------
module tb_issue_scheduler;

    localparam int NW = 8;
    localparam int BW = 3 + 32 + 9 + 8 * 4 + 32 + 16;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT signals ----------------
    logic [NW-1:0]    ibuf_valid;
    logic [NW-1:0]    ibuf_ready;
    logic [NW*32-1:0] ibuf_pc;
    logic [NW*9-1:0]  ibuf_op;
    logic [NW*8-1:0]  ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3;
    logic [NW*32-1:0] ibuf_imm;
    logic [NW*16-1:0] ibuf_tmask;
    logic             iss_valid, iss_ready;
    logic [2:0]       iss_wid;
    logic [31:0]      iss_pc;
    logic [8:0]       iss_op;
    logic [7:0]       iss_rd, iss_rs1, iss_rs2, iss_rs3;
    logic [31:0]      iss_imm;
    logic [15:0]      iss_tmask;
    logic             wb_valid;
    logic [2:0]       wb_wid;
    logic [7:0]       wb_rd;
    logic [31:0]      perf_issued, perf_stalls;

    issue_scheduler dut (
        .i_clk                (clk),
        .i_rst                (rst),
        .i_ibuf_valid         (ibuf_valid),
        .o_ibuf_ready         (ibuf_ready),
        .i_ibuf_pc            (ibuf_pc),
        .i_ibuf_op            (ibuf_op),
        .i_ibuf_rd            (ibuf_rd),
        .i_ibuf_rs1           (ibuf_rs1),
        .i_ibuf_rs2           (ibuf_rs2),
        .i_ibuf_rs3           (ibuf_rs3),
        .i_ibuf_imm32         (ibuf_imm),
        .i_ibuf_tmask         (ibuf_tmask),
        .o_iss_valid          (iss_valid),
        .i_iss_ready          (iss_ready),
        .o_iss_wid            (iss_wid),
        .o_iss_pc             (iss_pc),
        .o_iss_op             (iss_op),
        .o_iss_rd             (iss_rd),
        .o_iss_rs1            (iss_rs1),
        .o_iss_rs2            (iss_rs2),
        .o_iss_rs3            (iss_rs3),
        .o_iss_imm32          (iss_imm),
        .o_iss_tmask          (iss_tmask),
        .i_wb_valid           (wb_valid),
        .i_wb_wid             (wb_wid),
        .i_wb_rd              (wb_rd),
        .o_perf_issued        (perf_issued),
        .o_perf_hazard_stalls (perf_stalls)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int total = 0;
    int bad   = 0;
    logic [BW-1:0] exp_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] exp_bundle(input int w);
        return {3'(w), ibuf_pc[w*32 +: 32], ibuf_op[w*9 +: 9], ibuf_rd[w*8 +: 8],
                ibuf_rs1[w*8 +: 8], ibuf_rs2[w*8 +: 8], ibuf_rs3[w*8 +: 8],
                ibuf_imm[w*32 +: 32], ibuf_tmask[w*16 +: 16]};
    endfunction

    // ---------------- reference model (falling edge) ----------------
    logic [255:0] m_busy [NW];
    logic [NW-1:0] m_elig;
    logic [NW-1:0] m_exp_ready;
    logic          m_fire;
    logic          m_full   = 1'b0;
    int            m_ptr    = 0;
    int            m_sel;
    logic [31:0]   m_issued = '0;
    logic [31:0]   m_stalls = '0;
    logic [BW-1:0] m_front;

    initial begin
        for (int w = 0; w < NW; w++) m_busy[w] = '0;
    end

    always @(negedge clk) begin
        for (int w = 0; w < NW; w++) begin
            m_elig[w] = ibuf_valid[w]
                && !m_busy[w][ibuf_rd[w*8 +: 8]]  && !m_busy[w][ibuf_rs1[w*8 +: 8]]
                && !m_busy[w][ibuf_rs2[w*8 +: 8]] && !m_busy[w][ibuf_rs3[w*8 +: 8]];
        end
        m_fire = !m_full || iss_ready;
        m_sel  = -1;
        if (!rst && m_fire) begin
            for (int k = 0; k < NW; k++) begin
                if (m_sel < 0 && m_elig[(m_ptr + k) % NW]) m_sel = (m_ptr + k) % NW;
            end
        end
        m_exp_ready = (m_sel >= 0) ? 8'(1 << m_sel) : 8'h00;

        check("m_ibuf_ready", ibuf_ready, m_exp_ready);
        check("m_iss_valid", iss_valid, m_full);
        check("m_perf_issued", perf_issued, m_issued);
        check("m_perf_stalls", perf_stalls, m_stalls);

        if (!rst && m_full && iss_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL m_queue_underflow: got transfer want none (t=%0t)", $time);
            end else begin
                m_front = exp_q.pop_front();
                check("m_iss_bundle", {iss_wid, iss_pc, iss_op, iss_rd, iss_rs1, iss_rs2,
                                       iss_rs3, iss_imm, iss_tmask}, m_front);
            end
        end

        if (rst) begin
            for (int w = 0; w < NW; w++) m_busy[w] = '0;
            m_full   = 1'b0;
            m_ptr    = 0;
            m_issued = '0;
            m_stalls = '0;
            exp_q.delete();
        end else begin
            if (ibuf_valid != '0 && m_elig == '0) m_stalls++;
            if (wb_valid && wb_rd != 8'd0) m_busy[wb_wid][wb_rd] = 1'b0;
            if (m_sel >= 0) begin
                if (ibuf_rd[m_sel*8 +: 8] != 8'd0) m_busy[m_sel][ibuf_rd[m_sel*8 +: 8]] = 1'b1;
                exp_q.push_back(exp_bundle(m_sel));
                m_full = 1'b1;
                m_ptr  = (m_sel + 1) % NW;
                m_issued++;
            end else if (m_fire) begin
                m_full = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_warp(input int w, input logic [7:0] rd, input logic [7:0] rs1,
                            input logic [7:0] rs2, input logic [7:0] rs3);
        ibuf_valid[w]         = 1'b1;
        ibuf_rd[w*8 +: 8]     = rd;
        ibuf_rs1[w*8 +: 8]    = rs1;
        ibuf_rs2[w*8 +: 8]    = rs2;
        ibuf_rs3[w*8 +: 8]    = rs3;
        ibuf_pc[w*32 +: 32]   = $urandom;
        ibuf_op[w*9 +: 9]     = 9'($urandom);
        ibuf_imm[w*32 +: 32]  = $urandom;
        ibuf_tmask[w*16 +: 16] = 16'($urandom);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        ibuf_valid = '0;
        wb_valid   = 1'b0;
        iss_ready  = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          rst;
        logic [NW-1:0] valid;
        logic          rdy;
        logic [NW-1:0] exp_ready;
        logic          exp_v;
        logic [2:0]    exp_wid;
        logic [31:0]   exp_perf;
    } vec_t;

    vec_t vecs[14];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        ibuf_valid = '0;  ibuf_pc = '0;  ibuf_op = '0;  ibuf_rd = '0;
        ibuf_rs1 = '0;    ibuf_rs2 = '0; ibuf_rs3 = '0; ibuf_imm = '0; ibuf_tmask = '0;
        iss_ready = 1'b1; wb_valid = 1'b0; wb_wid = '0; wb_rd = '0;

        // Round-robin from reset with two warps, then all eight with wrap.
        vecs[0] = '{1'b1, 8'h05, 1'b1, 8'h00, 1'b0, 3'd0, 32'd0};
        vecs[1] = '{1'b0, 8'h05, 1'b1, 8'h01, 1'b1, 3'd0, 32'd1};
        vecs[2] = '{1'b0, 8'h05, 1'b1, 8'h04, 1'b1, 3'd2, 32'd2};
        vecs[3] = '{1'b0, 8'h05, 1'b1, 8'h01, 1'b1, 3'd0, 32'd3};
        vecs[4] = '{1'b1, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd0, 32'd0};
        for (int k = 0; k < 8; k++) begin
            vecs[5 + k] = '{1'b0, 8'hFF, 1'b1, 8'(1 << k), 1'b1, 3'(k), 32'(k + 1)};
        end
        vecs[13] = '{1'b0, 8'hFF, 1'b1, 8'h01, 1'b1, 3'd0, 32'd9};

        tick();
        tick();

        for (int i = 0; i < 14; i++) begin
            rst        = vecs[i].rst;
            ibuf_valid = vecs[i].valid;
            iss_ready  = vecs[i].rdy;
            #1;
            check($sformatf("tbl%0d_ready", i), ibuf_ready, vecs[i].exp_ready);
            tick();
            check($sformatf("tbl%0d_iss_valid", i), iss_valid, vecs[i].exp_v);
            check($sformatf("tbl%0d_iss_wid", i), iss_wid, vecs[i].exp_wid);
            check($sformatf("tbl%0d_perf", i), perf_issued, vecs[i].exp_perf);
        end

        // RAW block on warp 3 until the writeback edge, no bypass.
        do_reset();
        set_warp(3, 8'd5, 8'd0, 8'd0, 8'd0);
        #1 check("raw_first_issue", ibuf_ready, 8'h08);
        tick();
        set_warp(3, 8'd0, 8'd5, 8'd0, 8'd0);
        #1 check("raw_blocked", ibuf_ready, 8'h00);
        tick();
        wb_valid = 1'b1; wb_wid = 3'd3; wb_rd = 8'd5;
        #1 check("raw_no_wb_bypass", ibuf_ready, 8'h00);
        tick();
        wb_valid = 1'b0;
        #1 check("raw_after_wb", ibuf_ready, 8'h08);
        tick();
        check("raw_stalls", perf_stalls, 32'd2);
        check("raw_issued", perf_issued, 32'd2);
        ibuf_valid = '0;

        // Same-cycle writeback clear and issue set on one bit: set wins.
        do_reset();
        set_warp(4, 8'd5, 8'd0, 8'd0, 8'd0);
        wb_valid = 1'b1; wb_wid = 3'd4; wb_rd = 8'd5;
        #1 check("setclr_issue", ibuf_ready, 8'h10);
        tick();
        wb_valid = 1'b0;
        set_warp(4, 8'd0, 8'd0, 8'd5, 8'd0);
        #1 check("setclr_set_wins", ibuf_ready, 8'h00);
        tick();
        ibuf_valid = '0;

        // Back-pressure: output register holds for four cycles.
        do_reset();
        set_warp(1, 8'd0, 8'd0, 8'd0, 8'd0);
        ibuf_pc[1*32 +: 32] = 32'h1111_0000;
        #1 check("bp_first_issue", ibuf_ready, 8'h02);
        tick();
        iss_ready = 1'b0;
        ibuf_pc[1*32 +: 32] = 32'h2222_0000;
        for (int c = 0; c < 4; c++) begin
            #1 check("bp_ready_low", ibuf_ready, 8'h00);
            tick();
            check("bp_valid_held", iss_valid, 1'b1);
            check("bp_pc_held", iss_pc, 32'h1111_0000);
            check("bp_perf_held", perf_issued, 32'd1);
        end
        iss_ready = 1'b1;
        #1 check("bp_release_ready", ibuf_ready, 8'h02);
        tick();
        check("bp_next_pc", iss_pc, 32'h2222_0000);
        check("bp_next_perf", perf_issued, 32'd2);
        ibuf_valid = '0;

        // rd = 0 never marks a register busy.
        do_reset();
        set_warp(2, 8'd0, 8'd0, 8'd0, 8'd0);
        #1 check("r0_first", ibuf_ready, 8'h04);
        tick();
        set_warp(2, 8'd0, 8'd0, 8'd0, 8'd0);
        #1 check("r0_second", ibuf_ready, 8'h04);
        tick();
        check("r0_issued", perf_issued, 32'd2);
        check("r0_stalls", perf_stalls, 32'd0);
        ibuf_valid = '0;

        // Reset mid-operation discards the held bundle and busy bits.
        do_reset();
        iss_ready = 1'b0;
        set_warp(1, 8'd7, 8'd0, 8'd0, 8'd0);
        #1 check("mrst_first", ibuf_ready, 8'h02);
        tick();
        set_warp(1, 8'd0, 8'd7, 8'd0, 8'd0);
        #1 check("mrst_blocked", ibuf_ready, 8'h00);
        rst = 1'b1;
        #1 check("mrst_ready_in_reset", ibuf_ready, 8'h00);
        tick();
        rst = 1'b0;
        check("mrst_iss_valid", iss_valid, 1'b0);
        check("mrst_iss_data", {iss_wid, iss_pc, iss_op, iss_rd, iss_rs1, iss_rs2,
                                iss_rs3, iss_imm, iss_tmask}, '0);
        check("mrst_perf", perf_issued, 32'd0);
        #1 check("mrst_issue_r7", ibuf_ready, 8'h02);
        tick();
        check("mrst_iss_wid", iss_wid, 3'd1);
        ibuf_valid = '0;

        // Random traffic checked by the falling-edge model.
        do_reset();
        for (int c = 0; c < 300; c++) begin
            for (int w = 0; w < NW; w++) begin
                if ($urandom_range(0, 1) == 1)
                    set_warp(w, 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
                             8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)));
                else
                    ibuf_valid[w] = 1'b0;
            end
            iss_ready = ($urandom_range(0, 3) != 0);
            wb_valid  = ($urandom_range(0, 1) == 1);
            wb_wid    = 3'($urandom_range(0, 7));
            wb_rd     = 8'($urandom_range(0, 3));
            tick();
        end
        ibuf_valid = '0;
        wb_valid   = 1'b0;
        iss_ready  = 1'b1;
        tick();
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
